// File: rtl/udma_pkg.sv
// Shared uDMA types and event-router register map.
package udma_pkg;

  typedef logic [7:0] evt_id_t;

  localparam logic [4:0] REG_EVT_MASK0  = 5'h00;
  localparam logic [4:0] REG_EVT_MASK1  = 5'h01;
  localparam logic [4:0] REG_EVT_MASK2  = 5'h02;
  localparam logic [4:0] REG_EVT_MASK3  = 5'h03;
  localparam logic [4:0] REG_EVT_STATUS = 5'h04;
  localparam logic [4:0] REG_EVT_CTRL   = 5'h05;
  localparam logic [4:0] REG_EVT_SWTRIG = 5'h06;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_CLR_LOST_BIT = 1;
  localparam int CTRL_FLUSH_BIT    = 2;

  localparam logic [15:0] LOST_SAT = 16'hFFFF;

endpackage

// File: rtl/udma_evt_fifo.sv
// First-word fall-through FIFO with level/full/empty flags and single-cycle flush.
module udma_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign level   = count;
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  // Head is forced to 0 when empty so the unreset storage never reaches the outputs.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udma_evt_router.sv
// uDMA event router: pending latch, mask, round-robin arbiter and event-ID FIFO.
// Optional UDMA_EVT_ROUTER_TIMESTAMP_EN adds a 16-bit push timestamp per FIFO entry.
module udma_evt_router
  import udma_pkg::*;
#(
  parameter int N_PERIPHS  = 16,
  parameter int N_EVT      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_resetn_i,
  input  logic [N_PERIPHS*N_EVT-1:0] evt_i,
  input  logic [31:0]                cfg_data_i,
  input  logic [4:0]                 cfg_addr_i,
  input  logic                       cfg_valid_i,
  input  logic                       cfg_rwn_i,
  output logic                       cfg_ready_o,
  output logic [31:0]                cfg_data_o,
  output logic                       evt_valid_o,
  output logic [7:0]                 evt_data_o,
  output logic [15:0]                evt_ts_o,
  input  logic                       evt_ready_i
);

  localparam int N_SRC = N_PERIPHS * N_EVT;
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef UDMA_EVT_ROUTER_TIMESTAMP_EN
  localparam int ENTRY_W = 24;
`else
  localparam int ENTRY_W = 8;
`endif

  logic [N_SRC-1:0]   pending, mask, mask_nxt, set_vec, sw_vec, gnt_vec, loss_vec;
  logic [127:0]       mask_ext;
  logic               en, cfg_wr, flush, clr_lost, gnt_vld;
  logic [15:0]        lost;
  logic [IDX_W-1:0]   rr_ptr, gnt_idx, rr_nxt;
  logic [IDX_W:0]     scan;
  logic               fifo_full, fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;

  assign cfg_ready_o = cfg_valid_i;
  assign cfg_wr      = cfg_valid_i & ~cfg_rwn_i;
  assign flush       = cfg_wr & (cfg_addr_i == REG_EVT_CTRL) & cfg_data_i[CTRL_FLUSH_BIT];
  assign clr_lost    = cfg_wr & (cfg_addr_i == REG_EVT_CTRL) & cfg_data_i[CTRL_CLR_LOST_BIT];
  assign mask_ext    = 128'(mask);

  always_comb begin
    mask_nxt = mask;
    for (int b = 0; b < N_SRC; b++) begin
      if (cfg_addr_i[1:0] == 2'(b / 32)) mask_nxt[b] = cfg_data_i[b % 32];
    end
  end

  // Software trigger bypasses MASK and EN; out-of-range IDs are dropped.
  always_comb begin
    sw_vec = '0;
    if (cfg_wr && cfg_addr_i == REG_EVT_SWTRIG && {1'b0, cfg_data_i[7:0]} < 9'(N_SRC))
      sw_vec[cfg_data_i[IDX_W-1:0]] = 1'b1;
  end

  assign set_vec = flush ? '0 : ((evt_i & mask & {N_SRC{en}}) | sw_vec);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      scan = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (scan >= (IDX_W+1)'(N_SRC)) scan = scan - (IDX_W+1)'(N_SRC);
      if (!gnt_vld && pending[scan[IDX_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[IDX_W-1:0];
      end
    end
    // Full is sampled before any same-cycle pop, so a pop never frees the slot early.
    if (fifo_full || flush) gnt_vld = 1'b0;
  end

  always_comb begin
    gnt_vec          = '0;
    gnt_vec[gnt_idx] = gnt_vld;
  end

  assign rr_nxt   = (gnt_idx == IDX_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
  assign loss_vec = set_vec & pending & ~gnt_vec;

  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i) begin
      pending <= '0;
      mask    <= '0;
      en      <= 1'b0;
      lost    <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= flush ? '0 : ((pending & ~gnt_vec) | set_vec);
      if (gnt_vld) rr_ptr <= rr_nxt;
      if (cfg_wr && cfg_addr_i[4:2] == 3'b000) mask <= mask_nxt;
      if (cfg_wr && cfg_addr_i == REG_EVT_CTRL) en <= cfg_data_i[CTRL_EN_BIT];
      if (clr_lost)                           lost <= '0;
      else if (|loss_vec && lost != LOST_SAT) lost <= lost + 1'b1;
    end
  end

`ifdef UDMA_EVT_ROUTER_TIMESTAMP_EN
  logic [15:0] ts_cnt;

  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i) ts_cnt <= '0;
    else               ts_cnt <= ts_cnt + 1'b1;
  end

  assign fifo_din = {ts_cnt, evt_id_t'(gnt_idx)};
  assign evt_ts_o = fifo_dout[23:8];
`else
  assign fifo_din = evt_id_t'(gnt_idx);
  assign evt_ts_o = '0;
`endif

  udma_evt_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk_i),
    .rst_n (sys_resetn_i),
    .push  (gnt_vld),
    .din   (fifo_din),
    .pop   (evt_valid_o & evt_ready_i),
    .flush (flush),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign evt_valid_o = ~fifo_empty;
  assign evt_data_o  = fifo_dout[7:0];

  always_comb begin
    cfg_data_o = '0;
    case (cfg_addr_i)
      REG_EVT_MASK0:  cfg_data_o = mask_ext[31:0];
      REG_EVT_MASK1:  cfg_data_o = mask_ext[63:32];
      REG_EVT_MASK2:  cfg_data_o = mask_ext[95:64];
      REG_EVT_MASK3:  cfg_data_o = mask_ext[127:96];
      REG_EVT_STATUS: cfg_data_o = {fifo_full, |pending, 9'd0, 5'(fifo_level), lost};
      REG_EVT_CTRL:   cfg_data_o = {31'd0, en};
      default:        cfg_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_udma_evt_router.sv
// Directed + randomized bench for udma_evt_router against a queue-based reference model.
module tb_udma_evt_router;

  localparam int N_SRC = 64;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] evt_i;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic [4:0]  cfg_addr;
  logic        cfg_valid, cfg_rwn, cfg_ready;
  logic        evt_valid, evt_ready;
  logic [7:0]  evt_data;
  logic [15:0] evt_ts;

  int ncmp = 0;
  int nfail = 0;

  bit m_pend[N_SRC];
  bit m_mask[N_SRC];
  bit m_en;
  int m_q[$];
  int m_tsq[$];
  int m_rr, m_lost, m_ts;

  int          popped[$];
  logic        last_valid;
  logic [7:0]  last_data;
  logic [31:0] last_rd;

  udma_evt_router #(.N_PERIPHS(16), .N_EVT(4), .FIFO_DEPTH(8)) dut (
    .sys_clk_i    (clk),
    .sys_resetn_i (rst_n),
    .evt_i        (evt_i),
    .cfg_data_i   (cfg_wdata),
    .cfg_addr_i   (cfg_addr),
    .cfg_valid_i  (cfg_valid),
    .cfg_rwn_i    (cfg_rwn),
    .cfg_ready_o  (cfg_ready),
    .cfg_data_o   (cfg_rdata),
    .evt_valid_o  (evt_valid),
    .evt_data_o   (evt_data),
    .evt_ts_o     (evt_ts),
    .evt_ready_i  (evt_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_SRC; i++) begin
      m_pend[i] = 1'b0;
      m_mask[i] = 1'b0;
    end
    m_en = 1'b0;
    m_q.delete();
    m_tsq.delete();
    m_rr = 0;
    m_lost = 0;
    m_ts = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    logic [31:0] r;
    bit anyp;
    r = '0;
    anyp = 1'b0;
    for (int i = 0; i < N_SRC; i++) anyp |= m_pend[i];
    if (a < 5'd4) begin
      for (int b = 0; b < 32; b++)
        if (int'(a) * 32 + b < N_SRC) r[b] = m_mask[int'(a) * 32 + b];
    end else if (a == 5'd4) begin
      r[15:0]  = 16'(m_lost);
      r[20:16] = 5'(m_q.size());
      r[30]    = anyp;
      r[31]    = (m_q.size() == DEPTH);
    end else if (a == 5'd5) begin
      r[0] = m_en;
    end
    return r;
  endfunction

  // One clock of the reference: pop, flush, round-robin grant, set/loss, cfg writes.
  task automatic model_step();
    bit wr, fl, clr, full, loss, s;
    int g, k;
    wr   = cfg_valid && !cfg_rwn;
    fl   = wr && cfg_addr == 5'd5 && cfg_wdata[2];
    clr  = wr && cfg_addr == 5'd5 && cfg_wdata[1];
    full = (m_q.size() == DEPTH);
    if (m_q.size() > 0 && evt_ready) begin
      void'(m_q.pop_front());
      void'(m_tsq.pop_front());
    end
    if (fl) begin
      for (int i = 0; i < N_SRC; i++) m_pend[i] = 1'b0;
      m_q.delete();
      m_tsq.delete();
    end else begin
      g = -1;
      if (!full) begin
        for (int i = 0; i < N_SRC; i++) begin
          k = (m_rr + i) % N_SRC;
          if (m_pend[k]) begin
            g = k;
            break;
          end
        end
      end
      if (g >= 0) begin
        m_q.push_back(g);
        m_tsq.push_back(m_ts);
        m_pend[g] = 1'b0;
        m_rr = (g + 1) % N_SRC;
      end
      loss = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
        s = (evt_i[i] && m_mask[i] && m_en) ||
            (wr && cfg_addr == 5'd6 && int'(cfg_wdata[7:0]) == i);
        if (s) begin
          if (m_pend[i]) loss = 1'b1;
          m_pend[i] = 1'b1;
        end
      end
      if (loss && m_lost < 16'hFFFF) m_lost++;
    end
    if (clr) m_lost = 0;
    if (wr && cfg_addr < 5'd4)
      for (int b = 0; b < 32; b++)
        if (int'(cfg_addr) * 32 + b < N_SRC) m_mask[int'(cfg_addr) * 32 + b] = cfg_wdata[b];
    if (wr && cfg_addr == 5'd5) m_en = cfg_wdata[0];
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic step();
    @(negedge clk);
    last_valid = evt_valid;
    last_data  = evt_data;
    last_rd    = cfg_rdata;
    chk("evt_valid", 32'(evt_valid), (m_q.size() > 0) ? 32'd1 : 32'd0);
    chk("evt_data", 32'(evt_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
`ifdef UDMA_EVT_ROUTER_TIMESTAMP_EN
    chk("evt_ts", 32'(evt_ts), (m_tsq.size() > 0) ? 32'(m_tsq[0]) : 32'd0);
`else
    chk("evt_ts", 32'(evt_ts), 32'd0);
`endif
    chk("cfg_ready", 32'(cfg_ready), 32'(cfg_valid));
    if (cfg_valid && cfg_rwn) chk("cfg_rdata", cfg_rdata, model_rd(cfg_addr));
    if (evt_valid && evt_ready) popped.push_back(int'(evt_data));
    model_step();
    @(posedge clk);
    #1;
    evt_i     = '0;
    cfg_valid = 1'b0;
    cfg_rwn   = 1'b1;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_rwn   = 1'b0;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
  endtask

  task automatic cfg_read(input logic [4:0] a);
    cfg_valid = 1'b1;
    cfg_rwn   = 1'b1;
    cfg_addr  = a;
    step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    evt_i = '0;
    cfg_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ids[N_SRC];
    int exp_ids[$];
    int t, r;

    rst_n = 1'b0;
    evt_i = '0;
    cfg_wdata = '0;
    cfg_addr = '0;
    cfg_valid = 1'b0;
    cfg_rwn = 1'b1;
    evt_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_data", 32'(evt_data), 32'd0);
    chk("rst_evt_ts", 32'(evt_ts), 32'd0);
    chk("rst_cfg_data", cfg_rdata, 32'd0);
    apply_reset();
    cfg_read(5'd4);
    chk("rst_status", last_rd, 32'd0);

    // Single event: visible two cycles after the pulse.
    cfg_write(5'd5, 32'h1);
    cfg_write(5'd0, 32'h1);
    evt_i[0] = 1'b1;
    step();
    chk("lat_t0", 32'(last_valid), 32'd0);
    step();
    chk("lat_t1", 32'(last_valid), 32'd0);
    step();
    chk("lat_t2_valid", 32'(last_valid), 32'd1);
    chk("lat_t2_data", 32'(last_data), 32'd0);
    evt_ready = 1'b1;
    step();
    step();
    chk("t1_empty", 32'(last_valid), 32'd0);

    // All 64 sources at once drain in index order, one per cycle.
    apply_reset();
    evt_ready = 1'b1;
    cfg_write(5'd5, 32'h1);
    cfg_write(5'd0, 32'hFFFF_FFFF);
    cfg_write(5'd1, 32'hFFFF_FFFF);
    popped.delete();
    evt_i = '1;
    step();
    repeat (65) step();
    chk("burst_count", 32'(popped.size()), 32'd64);
    for (int i = 0; i < 64 && i < popped.size(); i++) chk("burst_order", 32'(popped[i]), 32'(i));
    cfg_read(5'd4);
    chk("burst_lost", 32'(last_rd[15:0]), 32'd0);

    // Back-pressure: 12 distinct sources, 8 queued and 4 left pending.
    for (int i = 0; i < N_SRC; i++) ids[i] = i;
    for (int i = N_SRC - 1; i > 0; i--) begin
      int j, tmp;
      j = $urandom_range(0, i);
      tmp = ids[i];
      ids[i] = ids[j];
      ids[j] = tmp;
    end
    evt_ready = 1'b0;
    exp_ids.delete();
    for (int i = 0; i < 12; i++) begin
      evt_i[ids[i]] = 1'b1;
      exp_ids.push_back(ids[i]);
    end
    step();
    repeat (12) step();
    cfg_read(5'd4);
    chk("bp_full", 32'(last_rd[31]), 32'd1);
    chk("bp_pending", 32'(last_rd[30]), 32'd1);
    chk("bp_level", 32'(last_rd[20:16]), 32'd8);
    popped.delete();
    evt_ready = 1'b1;
    repeat (20) step();
    chk("bp_drained", 32'(popped.size()), 32'd12);
    popped.sort();
    exp_ids.sort();
    for (int i = 0; i < 12 && i < popped.size(); i++) chk("bp_ids", 32'(popped[i]), 32'(exp_ids[i]));

    // Loss counting and saturation on source 5 while the FIFO is blocked.
    cfg_write(5'd5, 32'h3);
    evt_ready = 1'b0;
    evt_i[17:10] = 8'hFF;
    step();
    repeat (10) step();
    evt_i[5] = 1'b1;
    step();
    evt_i[5] = 1'b1;
    step();
    cfg_read(5'd4);
    chk("lost_one", 32'(last_rd[15:0]), 32'd1);
    for (int i = 0; i < 65536; i++) begin
      evt_i[5] = 1'b1;
      step();
    end
    cfg_read(5'd4);
    chk("lost_sat", 32'(last_rd[15:0]), 32'hFFFF);
    cfg_write(5'd5, 32'h3);
    cfg_read(5'd4);
    chk("lost_clr", 32'(last_rd[15:0]), 32'd0);
    evt_ready = 1'b1;
    repeat (15) step();

    // Round-robin fairness between two always-active sources.
    popped.delete();
    for (int i = 0; i < 24; i++) begin
      evt_i[3] = 1'b1;
      evt_i[40] = 1'b1;
      step();
    end
    chk("rr_enough", 32'(popped.size() >= 16), 32'd1);
    for (int i = 1; i < popped.size(); i++) begin
      chk("rr_member", 32'(popped[i] == 3 || popped[i] == 40), 32'd1);
      chk("rr_alternate", 32'(popped[i] != popped[i-1]), 32'd1);
    end
    repeat (6) step();

    // Software trigger ignores MASK/EN; out-of-range IDs are dropped.
    cfg_write(5'd0, 32'h0);
    cfg_write(5'd1, 32'h0);
    cfg_write(5'd5, 32'h0);
    evt_ready = 1'b0;
    cfg_write(5'd6, 32'h2A);
    repeat (3) step();
    chk("swtrig_valid", 32'(last_valid), 32'd1);
    chk("swtrig_id", 32'(last_data), 32'h2A);
    evt_ready = 1'b1;
    step();
    cfg_write(5'd6, 32'h50);
    repeat (3) step();
    chk("swtrig_oob", 32'(last_valid), 32'd0);

    // Flush with five entries queued.
    cfg_write(5'd0, 32'hFFFF_FFFF);
    cfg_write(5'd5, 32'h1);
    evt_ready = 1'b0;
    evt_i[4:0] = 5'h1F;
    step();
    repeat (7) step();
    cfg_read(5'd4);
    chk("flush_pre_level", 32'(last_rd[20:16]), 32'd5);
    cfg_write(5'd5, 32'h5);
    cfg_read(5'd4);
    chk("flush_level", 32'(last_rd[20:16]), 32'd0);
    chk("flush_pending", 32'(last_rd[30]), 32'd0);
    chk("flush_valid", 32'(last_valid), 32'd0);

    // Randomized traffic with occasional cfg accesses.
    for (int i = 0; i < 400; i++) begin
      evt_i = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      evt_ready = 1'($urandom_range(0, 1));
      t = $urandom_range(0, 15);
      if (t == 0) begin
        r = $urandom_range(0, 5);
        case (r)
          0: cfg_write(5'($urandom_range(0, 3)), $urandom);
          1: cfg_write(5'd5, {29'd0, 1'b0, 1'($urandom_range(0, 1)), 1'b1});
          2: cfg_write(5'd6, 32'($urandom_range(0, 80)));
          3: cfg_write(5'd5, ($urandom_range(0, 7) == 0) ? 32'h5 : 32'h1);
          default: cfg_read(5'($urandom_range(0, 7)));
        endcase
      end else begin
        step();
      end
    end

    // Asynchronous reset in the middle of a burst.
    cfg_write(5'd0, 32'hFFFF_FFFF);
    cfg_write(5'd1, 32'hFFFF_FFFF);
    cfg_write(5'd5, 32'h1);
    evt_ready = 1'b1;
    evt_i = '1;
    step();
    repeat (3) step();
    cfg_addr = 5'd4;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_data", 32'(evt_data), 32'd0);
    chk("mid_rst_ts", 32'(evt_ts), 32'd0);
    chk("mid_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("mid_rst_status", cfg_rdata, 32'd0);
    cfg_addr = 5'd0;
    #1;
    chk("mid_rst_mask", cfg_rdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    evt_ready = 1'b0;
    repeat (3) step();
    cfg_read(5'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
